// File: rtl/setup_sequencer_if.sv
// Placement-request / result bundle between the setup UI front end and the sequencer.
interface setup_sequencer_if #(
    parameter int X_bits = 10,
    parameter int Y_bits = 9
);
    logic              place_req;
    logic              done_req;
    logic [X_bits-1:0] cursor_x;
    logic [Y_bits-1:0] cursor_y;
    logic              nest_collision;
    logic [X_bits-1:0] collide_x;
    logic [Y_bits-1:0] collide_y;
    logic              SETUP_PHASE;
    logic              nest_set;
    logic              food_set;
    logic [3:0]        food_idx;
    logic [3:0]        food_count;
    logic              placed_ack;
    logic              reject;
    logic              busy;

    modport master (
        output place_req, done_req, cursor_x, cursor_y, nest_collision,
        input  collide_x, collide_y, SETUP_PHASE, nest_set, food_set,
               food_idx, food_count, placed_ack, reject, busy
    );

    modport slave (
        input  place_req, done_req, cursor_x, cursor_y, nest_collision,
        output collide_x, collide_y, SETUP_PHASE, nest_set, food_set,
               food_idx, food_count, placed_ack, reject, busy
    );
endinterface

// File: rtl/setup_sequencer.sv
// Setup sequencer: places the nest, then up to MAX_FOOD food sources, then enters RUN.
// Optional screen-edge rejection of placements is enabled by defining SETUP_EDGE_REJECT_EN.
module setup_sequencer #(
    parameter int X_bits      = 10,
    parameter int Y_bits      = 9,
    parameter int MAX_FOOD    = 8,
    parameter int EDGE_MARGIN = 8,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480
) (
    input logic               setup_clk,
    input logic               RESET_n,
    setup_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        NEST_WAIT, NEST_WR, FOOD_WAIT, FOOD_CHK, FOOD_WR, FOOD_REJ, RUN
    } state_t;

    if (MAX_FOOD < 1 || MAX_FOOD > 15 ||
        2*EDGE_MARGIN >= SCREEN_W || 2*EDGE_MARGIN >= SCREEN_H) begin : g_bad_cfg
        $error("setup_sequencer: illegal parameter set");
    end

    state_t            state, state_nxt;
    logic [X_bits-1:0] cx_q;
    logic [Y_bits-1:0] cy_q;
    logic [3:0]        count_q;
    logic              nest_edge;   // current cursor lies in the reject band
    logic              food_edge;   // latched band result for the candidate under check
    logic              nest_rej;    // registered reject for a refused nest placement
    logic              latch_nest, latch_food;

`ifdef SETUP_EDGE_REJECT_EN
    localparam logic [X_bits-1:0] X_LO = X_bits'(EDGE_MARGIN);
    localparam logic [X_bits-1:0] X_HI = X_bits'(SCREEN_W - EDGE_MARGIN);
    localparam logic [Y_bits-1:0] Y_LO = Y_bits'(EDGE_MARGIN);
    localparam logic [Y_bits-1:0] Y_HI = Y_bits'(SCREEN_H - EDGE_MARGIN);
    logic edge_q, nest_rej_q;

    assign nest_edge = (bus.cursor_x < X_LO) || (bus.cursor_x >= X_HI) ||
                       (bus.cursor_y < Y_LO) || (bus.cursor_y >= Y_HI);

    always_ff @(posedge setup_clk or negedge RESET_n) begin
        if (!RESET_n) begin
            edge_q     <= 1'b0;
            nest_rej_q <= 1'b0;
        end else begin
            if (latch_food) edge_q <= nest_edge;
            nest_rej_q <= (state == NEST_WAIT) && bus.place_req && nest_edge;
        end
    end

    assign food_edge = edge_q;
    assign nest_rej  = nest_rej_q;
`else
    assign nest_edge = 1'b0;
    assign food_edge = 1'b0;
    assign nest_rej  = 1'b0;
`endif

    always_ff @(posedge setup_clk or negedge RESET_n) begin
        if (!RESET_n) state <= NEST_WAIT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            NEST_WAIT: if (bus.place_req && !nest_edge) state_nxt = NEST_WR;
            NEST_WR:   state_nxt = FOOD_WAIT;
            // a done request wins over a coincident placement once food exists
            FOOD_WAIT: if (bus.done_req && count_q != 4'd0) state_nxt = RUN;
                       else if (bus.place_req)              state_nxt = FOOD_CHK;
            FOOD_CHK:  state_nxt = (bus.nest_collision || food_edge) ? FOOD_REJ : FOOD_WR;
            FOOD_WR:   state_nxt = (count_q == 4'(MAX_FOOD - 1)) ? RUN : FOOD_WAIT;
            FOOD_REJ:  state_nxt = FOOD_WAIT;
            RUN:       state_nxt = RUN;
            default:   state_nxt = NEST_WAIT;
        endcase
    end

    assign latch_nest = (state == NEST_WAIT) && (state_nxt == NEST_WR);
    assign latch_food = (state == FOOD_WAIT) && (state_nxt == FOOD_CHK);

    always_ff @(posedge setup_clk or negedge RESET_n) begin
        if (!RESET_n) begin
            cx_q    <= '0;
            cy_q    <= '0;
            count_q <= 4'd0;
        end else begin
            if (latch_nest || latch_food) begin
                cx_q <= bus.cursor_x;
                cy_q <= bus.cursor_y;
            end
            if (state == FOOD_WR) count_q <= count_q + 4'd1;
        end
    end

    logic setup_o, nest_set_o, food_set_o, ack_o, rej_o, busy_o;

    always_comb begin
        setup_o    = 1'b1;
        nest_set_o = 1'b0;
        food_set_o = 1'b0;
        ack_o      = 1'b0;
        rej_o      = nest_rej;
        busy_o     = 1'b0;
        case (state)
            NEST_WR:  begin nest_set_o = 1'b1; ack_o = 1'b1; busy_o = 1'b1; end
            FOOD_CHK: busy_o = 1'b1;
            FOOD_WR:  begin food_set_o = 1'b1; ack_o = 1'b1; busy_o = 1'b1; end
            FOOD_REJ: begin rej_o = 1'b1; busy_o = 1'b1; end
            RUN:      begin setup_o = 1'b0; rej_o = 1'b0; end
            default:  ;
        endcase
    end

    // count only advances after FOOD_WR, so it doubles as the slot index
    assign bus.food_idx    = count_q;
    assign bus.food_count  = count_q;
    assign bus.collide_x   = cx_q;
    assign bus.collide_y   = cy_q;
    assign bus.SETUP_PHASE = setup_o;
    assign bus.nest_set    = nest_set_o;
    assign bus.food_set    = food_set_o;
    assign bus.placed_ack  = ack_o;
    assign bus.reject      = rej_o;
    assign bus.busy        = busy_o;
endmodule
